// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-bit serial link: frame states, the default
// sync word and the parity helper used by both the transmitter and the detector.
package serial_link_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_DATA   = 2'd2,
      ST_PARITY = 2'd3
   } link_state_t;

   localparam int         LINK_SYNC_LEN = 4;
   localparam logic [3:0] LINK_SYNC     = 4'b1011;

   // Zero-extending a narrower word does not change its parity, so one width serves all callers.
   function automatic logic even_parity(input logic [31:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period counter: tick is high on the last clock of every bit period.
module bit_timer #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clock,
   input  logic reset_b,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

   logic [CNT_W-1:0] count;

   assign tick = (count == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         count <= '0;
      end else if (clear || tick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sync pattern, data MSB-first and optional even parity
// on a registered 1-bit line, fed through a valid/ready handshake.
module serial_frame_tx
   import serial_link_pkg::*;
#(
   parameter int                  WIDTH        = 8,
   parameter int                  SYNC_LEN     = LINK_SYNC_LEN,
   parameter logic [SYNC_LEN-1:0] SYNC         = LINK_SYNC,
   parameter int                  CLKS_PER_BIT = 1,
   parameter int                  PARITY_EN    = 1
) (
   input  logic             clock,
   input  logic             reset_b,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             Out,
   output logic             busy,
   output logic             done
);

   localparam int IDX_MAX = (WIDTH > SYNC_LEN) ? WIDTH : SYNC_LEN;
   localparam int IDX_W   = $clog2(IDX_MAX) + 1;

   link_state_t          state, state_next;
   logic [IDX_W-1:0]     idx;
   logic [WIDTH-1:0]     shift_reg;
   logic [SYNC_LEN-1:0]  sync_sr;
   logic                 parity_bit;
   logic                 out_d, busy_d, done_d;
   logic                 load, shift_data, shift_sync;
   logic                 last_bit, tick, clear;

   assign data_ready = (state == ST_IDLE);
   assign clear      = (state == ST_IDLE) || (state_next != state);

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clock  (clock),
      .reset_b(reset_b),
      .clear  (clear),
      .tick   (tick)
   );

   always_comb begin
      last_bit = 1'b1;
      case (state)
         ST_SYNC: last_bit = (idx == IDX_W'(SYNC_LEN - 1));
         ST_DATA: last_bit = (idx == IDX_W'(WIDTH - 1));
         default: last_bit = 1'b1;
      endcase
   end

   // Out is registered, so the value for the next bit is chosen here from the
   // MSB of the pending shift register at each bit boundary.
   always_comb begin
      state_next = state;
      out_d      = Out;
      busy_d     = busy;
      done_d     = 1'b0;
      load       = 1'b0;
      shift_data = 1'b0;
      shift_sync = 1'b0;
      case (state)
         ST_IDLE: begin
            out_d  = 1'b0;
            busy_d = 1'b0;
            if (data_valid) begin
               state_next = ST_SYNC;
               out_d      = SYNC[SYNC_LEN-1];
               busy_d     = 1'b1;
               load       = 1'b1;
            end
         end
         ST_SYNC: begin
            if (tick) begin
               if (last_bit) begin
                  state_next = ST_DATA;
                  out_d      = shift_reg[WIDTH-1];
                  shift_data = 1'b1;
               end else begin
                  out_d      = sync_sr[SYNC_LEN-1];
                  shift_sync = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (!last_bit) begin
                  out_d      = shift_reg[WIDTH-1];
                  shift_data = 1'b1;
               end else if (PARITY_EN != 0) begin
                  state_next = ST_PARITY;
                  out_d      = parity_bit;
               end else begin
                  state_next = ST_IDLE;
                  out_d      = 1'b0;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_next = ST_IDLE;
               out_d      = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         state      <= ST_IDLE;
         idx        <= '0;
         shift_reg  <= '0;
         sync_sr    <= '0;
         parity_bit <= 1'b0;
         Out        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state <= state_next;
         Out   <= out_d;
         busy  <= busy_d;
         done  <= done_d;
         if (state_next != state) begin
            idx <= '0;
         end else if (tick && state != ST_IDLE) begin
            idx <= idx + IDX_W'(1);
         end
         if (load) begin
            shift_reg  <= data_in;
            sync_sr    <= SYNC << 1;
            parity_bit <= even_parity(32'(data_in));
         end else begin
            if (shift_data) shift_reg <= shift_reg << 1;
            if (shift_sync) sync_sr <= sync_sr << 1;
         end
      end
   end

endmodule
